// File: rtl/lifo_seq_if.sv
// Valid/ready stream pair for lifo_seq: push-side input stream and pop-side output stream.
// master drives words in and accepts popped words; slave is the sequencer.
interface lifo_seq_if #(
    parameter int unsigned DW = 4
);
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/lifo_seq.sv
// Stream sequencer wrapped around an external LIFO stack: push strobes in, drain-to-empty out.
// Optional macro LIFO_SEQ_AUTO_DRAIN_EN: a full stack starts a drain on its own.
module lifo_seq #(
    parameter int unsigned DEPTH = 5,
    parameter int unsigned CW    = 3
) (
    input  logic          clk,
    input  logic          reset,
    lifo_seq_if.slave     bus,
    input  logic          drain_req,
    output logic          drain_done,
    output logic [CW-1:0] drain_count,
    output logic [CW-1:0] occ,
    output logic          mismatch,
    output logic          lifo_write,
    output logic          lifo_read,
    output logic [3:0]    lifo_data_in,
    input  logic [3:0]    lifo_data_out,
    input  logic          lifo_full,
    input  logic          lifo_empty
);
    localparam logic [CW-1:0] DepthCw = CW'(DEPTH);

    typedef enum logic [1:0] {StIdle, StPop, StCap, StOut} state_t;

    state_t        state_q;
    logic          out_valid_q;
    logic [3:0]    out_data_q;
    logic          drain_done_q;
    logic [CW-1:0] drain_count_q;
    logic [CW-1:0] occ_q;
    logic          mismatch_q;
    logic          lifo_read_q;
    logic          drain_go;
    logic          flag_err;

`ifdef LIFO_SEQ_AUTO_DRAIN_EN
    assign drain_go = drain_req | lifo_full;
`else
    assign drain_go = drain_req;
`endif

    assign bus.in_ready  = (state_q == StIdle) & ~lifo_full & ~drain_req;
    assign lifo_write    = bus.in_valid & bus.in_ready;
    assign lifo_data_in  = bus.in_data;
    assign lifo_read     = lifo_read_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign drain_done    = drain_done_q;
    assign drain_count   = drain_count_q;
    assign occ           = occ_q;
    assign mismatch      = mismatch_q;

    // A blocked increment/decrement can only happen when the mirror already disagrees.
    assign flag_err = ((occ_q == '0) != lifo_empty)
                    | ((occ_q == DepthCw) != lifo_full)
                    | (lifo_write & (occ_q == DepthCw))
                    | (lifo_read_q & (occ_q == '0));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= StIdle;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            drain_done_q  <= 1'b0;
            drain_count_q <= '0;
            occ_q         <= '0;
            mismatch_q    <= 1'b0;
            lifo_read_q   <= 1'b0;
        end else begin
            drain_done_q <= 1'b0;
            lifo_read_q  <= 1'b0;

            if (lifo_write && occ_q != DepthCw) begin
                occ_q <= occ_q + 1'b1;
            end else if (lifo_read_q && occ_q != '0) begin
                occ_q <= occ_q - 1'b1;
            end

            if (flag_err) begin
                mismatch_q <= 1'b1;
            end

            case (state_q)
                StIdle: begin
                    if (drain_go) begin
                        drain_count_q <= '0;
                        if (lifo_empty) begin
                            drain_done_q <= 1'b1;
                        end else begin
                            lifo_read_q <= 1'b1;
                            state_q     <= StPop;
                        end
                    end
                end
                StPop: begin
                    state_q <= StCap;
                end
                // LIFO read data is valid one cycle after the read strobe.
                StCap: begin
                    out_data_q  <= lifo_data_out;
                    out_valid_q <= 1'b1;
                    state_q     <= StOut;
                end
                StOut: begin
                    if (bus.out_ready) begin
                        out_valid_q   <= 1'b0;
                        drain_count_q <= drain_count_q + 1'b1;
                        if (lifo_empty) begin
                            drain_done_q <= 1'b1;
                            state_q      <= StIdle;
                        end else begin
                            lifo_read_q <= 1'b1;
                            state_q     <= StPop;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_lifo_seq.sv
// Directed bench for lifo_seq with a behavioural 5-entry LIFO (one-cycle read latency).
module tb_lifo_seq;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       lifo_rst_n = 1'b0;
    logic       drain_req = 1'b0;
    logic       drain_done;
    logic [2:0] drain_count;
    logic [2:0] occ;
    logic       mismatch;
    logic       lifo_write;
    logic       lifo_read;
    logic [3:0] lifo_data_in;
    logic [3:0] lifo_data_out;
    logic       lifo_full;
    logic       lifo_empty;
    logic       force_nonempty = 1'b0;

    int passed = 0;
    int total  = 0;
    int fails  = 0;
    int rd_cnt = 0;
    int wr_cnt = 0;
    int both_cnt = 0;
    int done_cnt = 0;

    always #5 clk = ~clk;

    lifo_seq_if #(.DW(4)) bus ();

    lifo_seq #(.DEPTH(5), .CW(3)) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus.slave),
        .drain_req    (drain_req),
        .drain_done   (drain_done),
        .drain_count  (drain_count),
        .occ          (occ),
        .mismatch     (mismatch),
        .lifo_write   (lifo_write),
        .lifo_read    (lifo_read),
        .lifo_data_in (lifo_data_in),
        .lifo_data_out(lifo_data_out),
        .lifo_full    (lifo_full),
        .lifo_empty   (lifo_empty)
    );

    // Behavioural stack
    logic [3:0] mem [8];
    logic [2:0] ptr;
    assign lifo_empty = (ptr == 3'd0) & ~force_nonempty;
    assign lifo_full  = (ptr == 3'd5);

    always_ff @(posedge clk or negedge lifo_rst_n) begin
        if (!lifo_rst_n) begin
            ptr           <= 3'd0;
            lifo_data_out <= 4'd0;
        end else if (lifo_write && ptr != 3'd5) begin
            mem[ptr] <= lifo_data_in;
            ptr      <= ptr + 3'd1;
        end else if (lifo_read && ptr != 3'd0) begin
            lifo_data_out <= mem[ptr - 3'd1];
            ptr           <= ptr - 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (lifo_read) rd_cnt <= rd_cnt + 1;
        if (lifo_write) wr_cnt <= wr_cnt + 1;
        if (lifo_read && lifo_write) both_cnt <= both_cnt + 1;
        if (drain_done) done_cnt <= done_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [3:0] d);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        #1;
        chk("push_ready", bus.in_ready, 1);
        chk("push_write", lifo_write, 1);
    endtask

    task automatic pulse_drain();
        @(negedge clk);
        bus.in_valid = 1'b0;
        drain_req    = 1'b1;
        @(negedge clk);
        drain_req = 1'b0;
    endtask

    // Waits for a popped word; stall > 0 holds out_ready low for that many cycles first.
    task automatic pop_word(input logic [3:0] exp, input int stall);
        int n = 0;
        int rd0;
        while (!bus.out_valid && n < 12) begin
            @(negedge clk);
            n++;
        end
        chk("wait_valid", bus.out_valid, 1);
        chk("out_data", bus.out_data, exp);
        if (stall > 0) begin
            bus.out_ready = 1'b0;
            rd0 = rd_cnt;
            for (int i = 0; i < stall; i++) begin
                @(negedge clk);
                chk("stall_valid", bus.out_valid, 1);
                chk("stall_data", bus.out_data, exp);
                chk("stall_no_read", rd_cnt, rd0);
            end
            bus.out_ready = 1'b1;
        end
        @(negedge clk);
    endtask

    initial begin
        int d0;
        int w0;
        int r0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 4'd0;
        bus.out_ready = 1'b1;

        // Reset state
        #12;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_occ", occ, 0);
        chk("rst_done", drain_done, 0);
        chk("rst_count", drain_count, 0);
        chk("rst_mismatch", mismatch, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        @(negedge clk);
        reset      = 1'b1;
        lifo_rst_n = 1'b1;

        // Three pushes then drain
        push(4'h3);
        push(4'h7);
        push(4'hA);
        d0 = done_cnt;
        pulse_drain();
        chk("t1_occ_before", occ, 3);
        chk("t1_read_n1", lifo_read, 1);
        chk("t1_in_ready_drain", bus.in_ready, 0);
        pop_word(4'hA, 0);
        pop_word(4'h7, 0);
        pop_word(4'h3, 0);
        chk("t1_done", drain_done, 1);
        @(negedge clk);
        chk("t1_done_low", drain_done, 0);
        chk("t1_done_pulses", done_cnt - d0, 1);
        chk("t1_count", drain_count, 3);
        chk("t1_occ", occ, 0);
        chk("t1_mismatch", mismatch, 0);

        // Six pushes with in_valid held high
        w0 = wr_cnt;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_data  = 4'(k + 1);
            #1;
            chk("t2_in_ready", bus.in_ready, (k < 5) ? 1 : 0);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("t2_writes", wr_cnt - w0, 5);
        chk("t2_occ", occ, 5);
`ifndef LIFO_SEQ_AUTO_DRAIN_EN
        chk("t2_full_no_drain", bus.in_ready, 0);
        pulse_drain();
`endif
        pop_word(4'h5, 0);
        pop_word(4'h4, 0);
        pop_word(4'h3, 0);
        pop_word(4'h2, 0);
        pop_word(4'h1, 0);
        chk("t2_done", drain_done, 1);
        @(negedge clk);
        chk("t2_count", drain_count, 5);
        chk("t2_mismatch", mismatch, 0);

        // Stall on the second word
        push(4'h9);
        push(4'hB);
        push(4'hC);
        pulse_drain();
        pop_word(4'hC, 0);
        pop_word(4'hB, 4);
        pop_word(4'h9, 0);
        chk("t3_done", drain_done, 1);
        @(negedge clk);
        chk("t3_count", drain_count, 3);
        chk("t3_occ", occ, 0);

        // Drain of an empty stack
        r0 = rd_cnt;
        d0 = done_cnt;
        pulse_drain();
        chk("t4_done", drain_done, 1);
        chk("t4_read", lifo_read, 0);
        chk("t4_count", drain_count, 0);
        @(negedge clk);
        chk("t4_done_low", drain_done, 0);
        chk("t4_no_reads", rd_cnt - r0, 0);
        chk("t4_done_pulses", done_cnt - d0, 1);

        // Reset while in CAP
        push(4'h1);
        push(4'h2);
        push(4'h3);
        pulse_drain();
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("t5_out_valid", bus.out_valid, 0);
        chk("t5_occ", occ, 0);
        chk("t5_in_ready", bus.in_ready, 1);
        @(negedge clk);
        chk("t5_idle_no_read", lifo_read, 0);
        lifo_rst_n = 1'b0;
        @(negedge clk);
        lifo_rst_n = 1'b1;
        reset      = 1'b1;
        push(4'h5);
        pulse_drain();
        pop_word(4'h5, 0);
        chk("t5_done", drain_done, 1);
        chk("t5_mismatch", mismatch, 0);

        // Forced flag disagreement
        @(negedge clk);
        force_nonempty = 1'b1;
        @(negedge clk);
        chk("t6_mismatch_set", mismatch, 1);
        force_nonempty = 1'b0;
        repeat (3) @(negedge clk);
        chk("t6_mismatch_sticky", mismatch, 1);
        reset = 1'b0;
        #1;
        chk("t6_mismatch_rst", mismatch, 0);
        @(negedge clk);
        reset = 1'b1;

        chk("no_read_write_overlap", both_cnt, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/lifo_seq.md
# lifo_seq

Stream-side sequencer that sits directly upstream and downstream of the 5-entry, 4-bit LIFO stack. It converts a valid/ready input stream into single-cycle LIFO write strobes. On a drain command it pops the stack until empty and presents each popped word on a valid/ready output stream. It never issues read and write together, absorbs the LIFO's one-cycle read latency, and keeps an occupancy mirror that is checked against the stack's full/empty flags.

## Interface
- DEPTH, 5: stack depth; must equal the attached LIFO depth.
- CW, 3: width of the occupancy and drain counters; must satisfy 2^CW > DEPTH.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  input word present.
- in_data  in  4  input word.
- in_ready  out  1  input word accepted this cycle when in_valid is also high.
- drain_req  in  1  level or pulse; requests a full pop-out, sampled in IDLE only.
- out_valid  out  1  popped word available.
- out_data  out  4  popped word, registered.
- out_ready  in  1  downstream accepts out_data.
- drain_done  out  1  one-cycle pulse when a drain completes.
- drain_count  out  CW  words delivered by the last drain, registered.
- occ  out  CW  occupancy mirror.
- mismatch  out  1  sticky; occ disagrees with the LIFO flags.
- lifo_write, lifo_read  out  1  strobes to the LIFO.
- lifo_data_in  out  4  equals in_data.
- lifo_data_out  in  4  LIFO data output.
- lifo_full, lifo_empty  in  1  LIFO status flags.

## Operation
- States: IDLE, POP, CAP, OUT. Encoding is free.
- IDLE, push path:
  - in_ready = (state==IDLE) & ~lifo_full & ~drain_req.
  - lifo_write = in_valid & in_ready, combinational.
  - On each accepted word, occ increments.
- IDLE, drain path: drain_req high while in IDLE:
  - If lifo_empty: stay in IDLE, pulse drain_done next cycle, set drain_count to 0.
  - Otherwise: clear drain_count and go to POP.
- POP: lifo_read=1 for exactly one cycle, occ decrements, then go to CAP.
- CAP: LIFO data_out is now valid; capture it into out_data at the end of the cycle, then go to OUT.
- OUT: out_valid=1, out_data held stable. When out_ready is high:
  - drain_count increments.
  - If lifo_empty: go to IDLE and pulse drain_done.
  - Otherwise: go to POP.
- lifo_read and lifo_write are never high in the same cycle.
- No push is accepted outside IDLE; in_ready stays 0 for the whole drain.
- Mismatch check, evaluated every cycle: mismatch sets if (occ==0) != lifo_empty or (occ==DEPTH) != lifo_full. It clears only on reset.
- occ never wraps: increment is blocked at DEPTH and decrement at 0. Both conditions also imply mismatch.

## Timing
- Reset (asynchronous assert, synchronous release), taking effect mid-operation as well:
  - State goes to IDLE.
  - out_valid, out_data, drain_done, drain_count, occ and mismatch go to 0.
  - in_ready follows its combinational equation, so it is 1 if the LIFO is not full.
  - LIFO contents are not touched by this block. A reset mid-drain abandons the in-flight word, and occ restarts at 0. System reset must therefore also reset the LIFO.
- Push: one word per cycle, zero latency from in_valid&in_ready to lifo_write. lifo_full is seen one cycle after the fifth push.
- Drain latency:
  - drain_req accepted at edge N.
  - lifo_read high in cycle N+1.
  - out_valid high from cycle N+3.
  - Minimum 3 cycles per word with out_ready held high.
- drain_done is high exactly one cycle: the cycle after the last out_valid&out_ready handshake, or after an empty drain.
- out_valid, once high, holds until out_ready; out_data does not change while out_valid=1.

## Configuration
- LIFO_SEQ_AUTO_DRAIN_EN defined: in IDLE, lifo_full=1 is treated as drain_req, so a drain starts automatically on the cycle the stack reports full.
- Undefined: drains start only on drain_req, and a full stack simply holds in_ready at 0.

## Test plan
- Push 0x3, 0x7, 0xA back-to-back, then pulse drain_req:
  - out_data sequence 0xA, 0x7, 0x3, each with out_valid.
  - drain_count=3, drain_done one pulse, occ=0, mismatch=0.
- Push 6 words with in_valid held high:
  - First 5 accepted.
  - in_ready=0 from the cycle after the fifth push; no sixth lifo_write.
  - With LIFO_SEQ_AUTO_DRAIN_EN, the drain starts and 5 words emerge in reverse order.
- Drain with out_ready low for 4 cycles on the second word:
  - out_valid stays 1 and out_data stays constant.
  - No lifo_read is issued during the stall; the remaining order is correct.
- drain_req on an empty stack: no lifo_read, drain_done one cycle later, drain_count=0.
- Assert reset in CAP state of a 3-word drain:
  - out_valid=0, occ=0, state IDLE immediately.
  - After the LIFO is also reset, a push of 0x5 then a drain returns 0x5.
- Force lifo_empty=0 while occ=0 (LIFO not reset): mismatch goes 1 next cycle and stays 1 until reset.
